// File: rtl/byte_data_memory_pkg.sv
// Shared definitions for the byte-addressable data memory: access size
// encodings, controller states, the latched request record and the helper
// that turns a size/offset pair into byte-lane enables.
package byte_data_memory_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Width of the wait-state counter (WAIT_STATES spans 0..15)
    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] write_data;
        logic [1:0]  size;
        logic        unsigned_load;
        logic        mem_write;
        logic        mem_read;
    } request_t;

    // Little-endian lane enables: byte offset 0 is lane 0 (bits [7:0])
    function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic [3:0] mask;
        case (size)
            SIZE_BYTE: mask = 4'b0001 << offset;
            SIZE_HALF: mask = 4'b0011 << offset;
            SIZE_WORD: mask = 4'b1111;
            default:   mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/byte_data_memory_word_ram.sv
// DEPTH x 32-bit storage with per-byte write enables and an asynchronous
// read port. The array holds each word XORed with its power-on image, so a
// zero-configured array reads back words 0..INIT_COUNT-1 as their own index
// and everything else as 0, without any reset or initial load of the array.
module word_ram #(
    parameter int DEPTH      = 1024,
    parameter int INIT_COUNT = 10,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          write_en,
    input  logic [3:0]    byte_en,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] init_image;

    // Power-on value of a word: its own index below INIT_COUNT, else zero
    function automatic logic [31:0] init_word(input logic [AW-1:0] idx);
        if (32'(idx) < 32'(INIT_COUNT)) begin
            return 32'(idx);
        end
        return 32'h0;
    endfunction

    // Power-on image of the addressed word, shared by the read and write paths
    always_comb begin
        init_image = init_word(addr);
    end

    // Combinational read, undoing the power-on image encoding
    always_comb begin
        read_data = mem[addr] ^ init_image;
    end

    // Byte-lane write; untouched lanes keep their stored value
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[addr][8*i +: 8] <= write_data[8*i +: 8] ^ init_image[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte/halfword/word data memory with a request/ready handshake and a
// programmable number of wait states. Misaligned or out-of-range requests
// complete with AddrError set and never touch the array.
module byte_data_memory
    import byte_data_memory_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int INIT_COUNT  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic        Busy,
    output logic        Ready,
    output logic [31:0] ReadData,
    output logic        AddrError
);

    localparam int AW = $clog2(DEPTH);

    state_t              state;
    logic [WAIT_W-1:0]   count;
    request_t            req_q;

    logic [1:0]          offset;
    logic [AW-1:0]       word_idx;
    logic                misaligned;
    logic                out_of_range;
    logic                access_err;
    logic                do_access;
    logic                ram_we;
    logic [3:0]          byte_en;
    logic [31:0]         lane_data;
    logic [31:0]         ram_rdata;
    logic [31:0]         shifted;
    logic [31:0]         load_value;

    // Capture the request on acceptance; data path needs no reset
    always_ff @(posedge Clk) begin
        if (state == ST_IDLE && Req) begin
            req_q <= '{address:       Address,
                       write_data:    WriteData,
                       size:          Size,
                       unsigned_load: Unsigned,
                       mem_write:     MemWrite,
                       mem_read:      MemRead};
        end
    end

    // Alignment and range check on the latched request
    always_comb begin
        offset       = req_q.address[1:0];
        word_idx     = req_q.address[AW+1:2];
        misaligned   = (req_q.size == 2'b11) ||
                       (req_q.size == SIZE_HALF && req_q.address[0]) ||
                       (req_q.size == SIZE_WORD && req_q.address[1:0] != 2'b00);
        out_of_range = req_q.address[31:2] >= 30'(DEPTH);
        // A request with neither strobe performs no access and cannot fault
        access_err   = (req_q.mem_write || req_q.mem_read) && (misaligned || out_of_range);
    end

    // Store path: replicate right-aligned data onto every lane it may target
    always_comb begin
        do_access = (state == ST_WAIT) && (count == '0);
        ram_we    = do_access && req_q.mem_write && !access_err;
        byte_en   = lane_mask(req_q.size, offset);
        case (req_q.size)
            SIZE_BYTE: lane_data = {4{req_q.write_data[7:0]}};
            SIZE_HALF: lane_data = {2{req_q.write_data[15:0]}};
            default:   lane_data = req_q.write_data;
        endcase
    end

    // Load path: bring the addressed lane(s) down to bit 0 and extend
    always_comb begin
        shifted = ram_rdata >> {offset, 3'b000};
        case (req_q.size)
            SIZE_BYTE: load_value = req_q.unsigned_load ? {24'h0, shifted[7:0]}
                                                        : {{24{shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_value = req_q.unsigned_load ? {16'h0, shifted[15:0]}
                                                        : {{16{shifted[15]}}, shifted[15:0]};
            default:   load_value = shifted;
        endcase
        // Stores (including store+load) and faulted accesses return zero
        if (!req_q.mem_read || req_q.mem_write || access_err) begin
            load_value = 32'h0;
        end
    end

    word_ram #(
        .DEPTH      (DEPTH),
        .INIT_COUNT (INIT_COUNT)
    ) u_word_ram (
        .clk        (Clk),
        .write_en   (ram_we),
        .byte_en    (byte_en),
        .addr       (word_idx),
        .write_data (lane_data),
        .read_data  (ram_rdata)
    );

    // Handshake controller: IDLE -> WAIT (count down) -> DONE -> IDLE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            Busy      <= 1'b0;
            Ready     <= 1'b0;
            ReadData  <= 32'h0;
            AddrError <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        count <= WAIT_W'(WAIT_STATES);
                        Busy  <= 1'b1;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        Ready     <= 1'b1;
                        ReadData  <= load_value;
                        AddrError <= access_err;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    Ready     <= 1'b0;
                    ReadData  <= 32'h0;
                    AddrError <= 1'b0;
                    Busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_data_memory.sv
// Bench for byte_data_memory: two instances (0 and 3 wait states) driven by
// directed and random accesses, compared against a byte-array model.
module tb_byte_data_memory;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req  [2];
    logic        we   [2];
    logic        re   [2];
    logic        uns  [2];
    logic [1:0]  sz   [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic        busy [2];
    logic        ready[2];
    logic        aerr [2];
    logic [31:0] rdata[2];

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Model memory: plain little-endian byte arrays, one per instance
    logic [7:0] mem_m [2][4*DEPTH];

    byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(0), .INIT_COUNT(10)) dut0 (
        .Clk(clk), .Reset(rst), .Req(req[0]), .MemWrite(we[0]), .MemRead(re[0]),
        .Size(sz[0]), .Unsigned(uns[0]), .Address(addr[0]), .WriteData(wd[0]),
        .Busy(busy[0]), .Ready(ready[0]), .ReadData(rdata[0]), .AddrError(aerr[0]));

    byte_data_memory #(.DEPTH(DEPTH), .WAIT_STATES(3), .INIT_COUNT(10)) dut3 (
        .Clk(clk), .Reset(rst), .Req(req[1]), .MemWrite(we[1]), .MemRead(re[1]),
        .Size(sz[1]), .Unsigned(uns[1]), .Address(addr[1]), .WriteData(wd[1]),
        .Busy(busy[1]), .Ready(ready[1]), .ReadData(rdata[1]), .AddrError(aerr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour: returns expected ReadData/AddrError and applies stores
    function automatic void model(input int u, input logic w, input logic r,
                                  input logic [1:0] s, input logic un,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] v;
        rd  = 32'h0;
        err = 1'b0;
        if (!w && !r) return;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        if (s == 2'd3 || (a % n) != 0 || (a / 4) >= DEPTH) begin
            err = 1'b1;
            return;
        end
        if (w) begin
            for (int i = 0; i < n; i++) mem_m[u][int'(a) + i] = d[8*i +: 8];
            return;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mem_m[u][int'(a) + i];
        if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        rd = v;
    endfunction

    // Issue one request and check the handshake on every cycle until it retires
    task automatic access(input int u, input logic w, input logic r,
                          input logic [1:0] s, input logic un,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic hold,
                          output logic [31:0] erd, output logic eerr);
        int lat;
        lat = (u == 0) ? 0 : 3;
        model(u, w, r, s, un, a, d, erd, eerr);
        @(negedge clk);
        req[u] = 1'b1; we[u] = w; re[u] = r; sz[u] = s; uns[u] = un;
        addr[u] = a; wd[u] = d;
        @(negedge clk);
        check("busy_after_accept", {31'h0, busy[u]}, 32'h1);
        check("ready_after_accept", {31'h0, ready[u]}, 32'h0);
        if (!hold) begin
            // Scramble the inputs: the request must already be latched
            req[u] = 1'b0;
            addr[u] = $urandom; wd[u] = $urandom;
            sz[u] = 2'($urandom_range(0, 3)); uns[u] = 1'($urandom);
        end
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k <= lat) begin
                check("busy_wait", {31'h0, busy[u]}, 32'h1);
                check("ready_wait", {31'h0, ready[u]}, 32'h0);
            end else if (k == lat + 1) begin
                check("ready_pulse", {31'h0, ready[u]}, 32'h1);
                check("busy_at_ready", {31'h0, busy[u]}, 32'h1);
                check("read_data", rdata[u], erd);
                check("addr_error", {31'h0, aerr[u]}, {31'h0, eerr});
            end else begin
                check("busy_fall", {31'h0, busy[u]}, 32'h0);
                check("ready_fall", {31'h0, ready[u]}, 32'h0);
                req[u] = 1'b0;
            end
        end
        @(negedge clk);
        check("no_reaccept_busy", {31'h0, busy[u]}, 32'h0);
        check("no_reaccept_ready", {31'h0, ready[u]}, 32'h0);
    endtask

    // ReadData must be zero whenever Ready is low
    always @(negedge clk) begin
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                if (!ready[u]) check("idle_read_data", rdata[u], 32'h0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;

        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 4*DEPTH; i++) mem_m[u][i] = 8'h00;
            for (int w = 0; w < 10; w++) mem_m[u][4*w] = 8'(w);
            req[u] = 0; we[u] = 0; re[u] = 0; uns[u] = 0; sz[u] = 0; addr[u] = 0; wd[u] = 0;
        end

        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("reset_busy", {31'h0, busy[u]}, 32'h0);
            check("reset_ready", {31'h0, ready[u]}, 32'h0);
            check("reset_read_data", rdata[u], 32'h0);
            check("reset_addr_error", {31'h0, aerr[u]}, 32'h0);
        end
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Initial contents and the zero-wait latency
        access(0, 0, 1, 2'b10, 0, 32'h14, 32'h0, 0, r, e);
        check("pin_init_word5", r, 32'h5);

        // Byte store then word/byte loads
        access(0, 1, 0, 2'b00, 0, 32'h09, 32'h0000_00F0, 0, r, e);
        access(0, 0, 1, 2'b10, 0, 32'h08, 32'h0, 0, r, e);
        check("pin_word_after_byte", r, 32'h0000_F002);
        access(0, 0, 1, 2'b00, 0, 32'h09, 32'h0, 0, r, e);
        check("pin_byte_signed", r, 32'hFFFF_FFF0);
        access(0, 0, 1, 2'b00, 1, 32'h09, 32'h0, 0, r, e);
        check("pin_byte_unsigned", r, 32'h0000_00F0);

        // Halfword store, signed load, misaligned accesses
        access(0, 1, 0, 2'b01, 0, 32'h0E, 32'h0000_8001, 0, r, e);
        access(0, 0, 1, 2'b01, 0, 32'h0E, 32'h0, 0, r, e);
        check("pin_half_signed", r, 32'hFFFF_8001);
        access(0, 0, 1, 2'b01, 0, 32'h0F, 32'h0, 0, r, e);
        check("pin_half_misaligned_err", {31'h0, e}, 32'h1);
        access(0, 1, 0, 2'b01, 0, 32'h0F, 32'h0000_5555, 0, r, e);
        access(0, 0, 1, 2'b10, 0, 32'h0C, 32'h0, 0, r, e);
        check("pin_word3_unchanged", r, 32'h8001_0003);

        // Out of range store must not alias onto word 0
        access(0, 1, 0, 2'b10, 0, 32'h1000, 32'hFFFF_FFFF, 0, r, e);
        check("pin_out_of_range_err", {31'h0, e}, 32'h1);
        access(0, 0, 1, 2'b10, 0, 32'h0, 32'h0, 0, r, e);
        check("pin_word0_zero", r, 32'h0);

        // Size 11, no-strobe request, store+load together
        access(0, 0, 1, 2'b11, 0, 32'h0, 32'h0, 0, r, e);
        access(0, 0, 0, 2'b11, 0, 32'h3, 32'h0, 0, r, e);
        access(0, 1, 1, 2'b10, 0, 32'h40, 32'h1234_5678, 0, r, e);
        access(0, 0, 1, 2'b10, 0, 32'h40, 32'h0, 0, r, e);
        check("pin_store_priority", r, 32'h1234_5678);

        // Wait-state instance: latency and Req held high while busy
        access(1, 0, 1, 2'b10, 0, 32'h14, 32'h0, 0, r, e);
        access(1, 0, 1, 2'b01, 1, 32'h18, 32'h0, 1, r, e);
        check("pin_held_req_half", r, 32'h6);

        // Reset during WAIT aborts the store
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b1; re[1] = 1'b0; sz[1] = 2'b10; uns[1] = 1'b0;
        addr[1] = 32'h20; wd[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        req[1] = 1'b0;
        check("abort_busy_before", {31'h0, busy[1]}, 32'h1);
        rst = 1'b1;
        #1;
        check("abort_busy_async", {31'h0, busy[1]}, 32'h0);
        check("abort_ready_async", {31'h0, ready[1]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("abort_no_ready", {31'h0, ready[1]}, 32'h0);
        end
        access(1, 0, 1, 2'b10, 0, 32'h20, 32'h0, 0, r, e);
        check("pin_aborted_word8", r, 32'h8);

        // Random traffic on both instances
        for (int u = 0; u < 2; u++) begin
            for (int n = 0; n < 150; n++) begin
                logic [31:0] ra;
                ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
                access(u, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)),
                       1'($urandom), ra, $urandom, 1'($urandom_range(0, 7) == 0), r, e);
            end
        end

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/byte_data_memory.md
# byte_data_memory

Parametrised data memory for the MIPS datapath, replacing the fixed word-only, zero-latency data memory. Supports byte, halfword and word accesses with byte-lane writes and sign or zero extension on loads. A request/ready handshake and a configurable wait-state counter model slow memory for stall testing. Misaligned or out-of-range accesses are flagged and never modify memory.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; power of two.
- WAIT_STATES, 0: extra cycles inserted before each access completes; range 0..15.
- INIT_COUNT, 10: words 0..INIT_COUNT-1 initialise to their own index; all other words initialise to 0.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Req  in  1  request strobe; sampled only while Busy=0.
- MemWrite  in  1  store request; takes priority over MemRead.
- MemRead  in  1  load request.
- Size  in  2  access size: 00 = byte, 01 = halfword, 10 = word; 11 is treated as a misaligned access.
- Unsigned  in  1  zero-extends byte or halfword loads when high; sign-extends when low.
- Address  in  32  byte address.
- WriteData  in  32  store data, right-aligned: byte in [7:0], halfword in [15:0].
- Busy  out  1  high from the accepting edge until the cycle after Ready.
- Ready  out  1  one-cycle completion pulse.
- ReadData  out  32  extended load result; valid while Ready=1, otherwise 0.
- AddrError  out  1  valid with Ready; high for a misaligned or out-of-range access.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE with Req=1:
  - latch Address, WriteData, Size, Unsigned, MemWrite and MemRead;
  - load the counter with WAIT_STATES;
  - go to WAIT.
- WAIT, counter nonzero: decrement the counter.
- WAIT, counter zero: perform the access, register the outputs, set Ready=1, go to DONE.
- DONE: go to IDLE unconditionally. Req is ignored in WAIT and DONE.
- Error check, evaluated on the latched request:
  - misaligned: halfword with Address[0]=1, word with Address[1:0]≠0, or Size=11;
  - out of range: Address[31:2] ≥ DEPTH.
- On error: no write, ReadData=0, AddrError=1, same latency as a normal access.
- Byte lanes are little-endian: byte offset 0 maps to bits [7:0].
- A store writes only the addressed lane(s); the other bytes of the word are unchanged.
- A load selects the addressed lane(s) and extends to 32 bits according to Unsigned.
- MemWrite and MemRead both high: the access is a store, and ReadData=0.
- Req with neither MemWrite nor MemRead: no access; Ready pulses with ReadData=0 and AddrError=0.
- Memory contents are not affected by Reset.

## Timing
- All outputs reset to 0 and the state resets to IDLE immediately on Reset assertion.
- Reset during WAIT or DONE aborts the request: no write occurs, and no Ready is issued after Reset releases.
- Request accepted at edge E0:
  - access and Ready at edge E0+WAIT_STATES+1;
  - Ready falls and Busy falls at the following edge;
  - a new Req is accepted at the earliest one edge after Busy falls.
- Throughput: one access per WAIT_STATES+3 cycles.
- A store is visible to a load accepted after its Ready.

## Structure
- Package byte_data_memory_pkg holds:
  - size encodings SIZE_BYTE, SIZE_HALF, SIZE_WORD;
  - the FSM state enum;
  - WAIT counter width (4 bits).
- Sub-module word_ram:
  - DEPTH×32 array with 4-bit byte-enable synchronous write and combinational read;
  - INIT_COUNT initialisation.
- The top level holds the FSM, the request latches, the lane/extension logic and the error check.

## Test plan
- Reset values and initial contents (WAIT_STATES=0): after Reset, word load at Address 0x14 returns 5; Ready is seen exactly 1 edge after the accepting edge.
- Byte store and signed/unsigned loads:
  - store byte 0xF0 at 0x09, then word load at 0x08 returns 0x0000F002;
  - byte load at 0x09 returns 0xFFFFFFF0 with Unsigned=0 and 0x000000F0 with Unsigned=1.
- Halfword store and errors:
  - halfword store 0x8001 at 0x0E, then signed halfword load at 0x0E returns 0xFFFF8001;
  - halfword load at 0x0F gives AddrError=1, ReadData=0, and memory is unchanged.
- Out of range: word store at 0x1000 with DEPTH=1024 gives AddrError=1, and word 0 still reads 0.
- Wait states and stall: WAIT_STATES=3 gives Ready 4 edges after acceptance; a Req held high while Busy is not double-accepted.
- Reset mid-operation: Reset asserted in WAIT of a word store of 0xDEADBEEF at 0x20 means no Ready appears, and word 0x20 still reads 8.
